// File: rtl/adc_spi_responder.sv
// SPI responder emulating an MCP3208-style ADC: decodes start/SGL/channel from DIN
// and returns the selected ch_data slice on DOUT, oversampling the bus on controlCLK.
module adc_spi_responder #(
  parameter int unsigned DATA_W  = 12,
  parameter int unsigned CH_BITS = 3
) (
  input  logic                            controlCLK,
  input  logic                            reset,
  input  logic                            CS,
  input  logic                            SCLK,
  input  logic                            DIN,
  output logic                            DOUT,
  output logic                            DOUT_OE,
  input  logic [DATA_W*(2**CH_BITS)-1:0]  ch_data,
  output logic                            cmd_valid,
  output logic                            cmd_single,
  output logic [CH_BITS-1:0]              cmd_channel,
  output logic                            busy
);

  localparam int unsigned CntW = $clog2(DATA_W + 1);

  typedef enum logic [2:0] {StIdle, StCmd, StSample, StData, StTail} state_e;

  logic              r_cs_s1, r_cs_s2;
  logic              r_sclk_s1, r_sclk_s2, r_sclk_s3;
  logic              r_din_s1, r_din_s2;
  logic [1:0]        r_sync_ok;
  logic              r_armed;
  state_e            r_state;
  logic [CntW-1:0]   r_bitcnt;
  logic [CH_BITS-1:0] r_cmd;
  logic [DATA_W-1:0] r_shift;
  logic              r_dout, r_dout_oe, r_cmd_valid, r_cmd_single, r_busy;
  logic [CH_BITS-1:0] r_cmd_channel;

  logic              w_rise, w_fall;
  logic [CH_BITS:0]  w_cmd_full;
  logic [CH_BITS-1:0] w_ch;
  logic [DATA_W-1:0] w_slice;

  assign w_rise     = r_sclk_s2 & ~r_sclk_s3;
  assign w_fall     = ~r_sclk_s2 & r_sclk_s3;
  assign w_cmd_full = {r_cmd, r_din_s2};
  assign w_ch       = w_cmd_full[CH_BITS-1:0];
  assign w_slice    = ch_data[32'(w_ch) * DATA_W +: DATA_W];

  // r_sync_ok marks when the CS synchronizer holds a real pin sample rather than its preset.
  always_ff @(posedge controlCLK or posedge reset) begin
    if (reset) begin
      r_cs_s1   <= 1'b1;
      r_cs_s2   <= 1'b1;
      r_sclk_s1 <= 1'b0;
      r_sclk_s2 <= 1'b0;
      r_sclk_s3 <= 1'b0;
      r_din_s1  <= 1'b0;
      r_din_s2  <= 1'b0;
      r_sync_ok <= '0;
    end else begin
      r_cs_s1   <= CS;
      r_cs_s2   <= r_cs_s1;
      r_sclk_s1 <= SCLK;
      r_sclk_s2 <= r_sclk_s1;
      r_sclk_s3 <= r_sclk_s2;
      r_din_s1  <= DIN;
      r_din_s2  <= r_din_s1;
      r_sync_ok <= {r_sync_ok[0], 1'b1};
    end
  end

  always_ff @(posedge controlCLK or posedge reset) begin
    if (reset) begin
      r_state       <= StIdle;
      r_bitcnt      <= '0;
      r_cmd         <= '0;
      r_shift       <= '0;
      r_dout        <= 1'b0;
      r_dout_oe     <= 1'b0;
      r_cmd_valid   <= 1'b0;
      r_cmd_single  <= 1'b0;
      r_cmd_channel <= '0;
      r_busy        <= 1'b0;
      r_armed       <= 1'b0;
    end else begin
      r_cmd_valid <= 1'b0;
      if (r_cs_s2) begin
        // Abort has priority over any SCLK edge seen in the same cycle.
        r_state   <= StIdle;
        r_bitcnt  <= '0;
        r_dout    <= 1'b0;
        r_dout_oe <= 1'b0;
        r_busy    <= 1'b0;
        if (r_sync_ok[1]) r_armed <= 1'b1;
      end else begin
        unique case (r_state)
          StIdle: begin
            if (w_rise && r_din_s2 && r_armed) begin
              r_state  <= StCmd;
              r_bitcnt <= '0;
              r_busy   <= 1'b1;
            end
          end
          StCmd: begin
            if (w_rise) begin
              r_cmd <= w_cmd_full[CH_BITS-1:0];
              if (r_bitcnt == CntW'(CH_BITS)) begin
                r_shift       <= w_slice;
                r_cmd_single  <= w_cmd_full[CH_BITS];
                r_cmd_channel <= w_ch;
                r_cmd_valid   <= 1'b1;
                r_dout_oe     <= 1'b1;
                r_bitcnt      <= '0;
                r_state       <= StSample;
              end else begin
                r_bitcnt <= r_bitcnt + CntW'(1);
              end
            end
          end
          StSample: begin
            // bitcnt flags that the sample-clock rise has been seen.
            if (w_rise) begin
              r_bitcnt <= CntW'(1);
            end else if (w_fall && (r_bitcnt != '0)) begin
              r_dout   <= 1'b0;
              r_bitcnt <= '0;
              r_state  <= StData;
            end
          end
          StData: begin
            if (w_fall) begin
              if (r_bitcnt == CntW'(DATA_W)) begin
                r_dout  <= 1'b0;
                r_state <= StTail;
              end else begin
                r_dout   <= r_shift[DATA_W-1];
                r_shift  <= r_shift << 1;
                r_bitcnt <= r_bitcnt + CntW'(1);
              end
            end
          end
          StTail: r_dout <= 1'b0;
          default: r_state <= StIdle;
        endcase
      end
    end
  end

  assign DOUT        = r_dout;
  assign DOUT_OE     = r_dout_oe;
  assign cmd_valid   = r_cmd_valid;
  assign cmd_single  = r_cmd_single;
  assign cmd_channel = r_cmd_channel;
  assign busy        = r_busy;

endmodule

// File: tb/tb_adc_spi_responder.sv
// Directed bench for adc_spi_responder: drives SPI mode-0 frames with a 6-cycle SCLK half period
// and checks decoded command, DOUT data and abort/reset behaviour against hand-computed values.
module tb_adc_spi_responder;

  logic        clk = 1'b0;
  logic        rst, cs, sclk, din;
  logic        dout, dout_oe, cmd_valid, cmd_single, busy;
  logic [2:0]  cmd_channel;
  logic [95:0] ch_data;

  int tests = 0;
  int fails = 0;
  int valid_cnt = 0;

  logic        q, nb, ok;
  logic [11:0] res;
  logic [3:0]  part;
  int          vc;

  always #5 clk = ~clk;

  adc_spi_responder #(.DATA_W(12), .CH_BITS(3)) dut (
    .controlCLK (clk),
    .reset      (rst),
    .CS         (cs),
    .SCLK       (sclk),
    .DIN        (din),
    .DOUT       (dout),
    .DOUT_OE    (dout_oe),
    .ch_data    (ch_data),
    .cmd_valid  (cmd_valid),
    .cmd_single (cmd_single),
    .cmd_channel(cmd_channel),
    .busy       (busy)
  );

  always @(negedge clk) if (cmd_valid) valid_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One SCLK period; d is presented while low, DOUT is sampled just before the rise.
  task automatic sbit(input logic d, output logic s);
    din = d;
    clks(6);
    s = dout;
    sclk = 1'b1;
    clks(6);
    sclk = 1'b0;
  endtask

  task automatic send_cmd(input int zeros, input logic sgl, input logic [2:0] ch);
    logic t;
    cs = 1'b0;
    clks(4);
    for (int i = 0; i < zeros; i++) sbit(1'b0, t);
    check("idle_after_zeros", {busy, dout_oe}, 2'b00);
    sbit(1'b1, t);
    check("start_busy_oe", {busy, dout_oe}, 2'b10);
    sbit(sgl, t);
    for (int i = 2; i >= 0; i--) sbit(ch[i], t);
  endtask

  task automatic read_bits(output logic [11:0] r, output logic nul);
    logic t;
    sbit(1'b0, nul);
    for (int i = 11; i >= 0; i--) begin
      sbit(1'b0, t);
      r[i] = t;
    end
  endtask

  task automatic end_frame();
    clks(3);
    cs = 1'b1;
    clks(8);
  endtask

  initial begin
    rst = 1'b1; cs = 1'b1; sclk = 1'b0; din = 1'b0; ch_data = '0;
    clks(3);
    check("reset_state", {26'd0, dout, dout_oe, cmd_valid, cmd_single, busy, cmd_channel}, 32'd0);
    rst = 1'b0;
    clks(6);

    // Single-ended read of channel 5
    ch_data[5*12 +: 12] = 12'hA5C;
    vc = valid_cnt;
    send_cmd(0, 1'b1, 3'd5);
    check("t1_valid_cnt", valid_cnt, vc + 1);
    check("t1_single", cmd_single, 1'b1);
    check("t1_channel", cmd_channel, 3'd5);
    sbit(1'b0, q);
    check("t1_oe_after_sample", dout_oe, 1'b1);
    read_bits(res, nb);
    check("t1_null", nb, 1'b0);
    check("t1_data", res, 12'hA5C);
    end_frame();
    check("t1_idle_after_cs", {busy, dout_oe}, 2'b00);

    // Leading zeros, differential channel 2
    ch_data[2*12 +: 12] = 12'h001;
    vc = valid_cnt;
    send_cmd(3, 1'b0, 3'd2);
    check("t2_valid_cnt", valid_cnt, vc + 1);
    check("t2_single", cmd_single, 1'b0);
    check("t2_channel", cmd_channel, 3'd2);
    sbit(1'b0, q);
    read_bits(res, nb);
    check("t2_null", nb, 1'b0);
    check("t2_data", res, 12'h001);
    end_frame();

    // Capture freeze: ch0 changes one SCLK after cmd_valid
    ch_data[0 +: 12] = 12'hFFF;
    send_cmd(0, 1'b1, 3'd0);
    check("t3_channel", cmd_channel, 3'd0);
    sbit(1'b0, q);
    ch_data[0 +: 12] = 12'h000;
    read_bits(res, nb);
    check("t3_data_frozen", res, 12'hFFF);
    end_frame();

    // Mid-data abort after 4 bits of channel 3
    ch_data[3*12 +: 12] = 12'h555;
    vc = valid_cnt;
    send_cmd(0, 1'b1, 3'd3);
    sbit(1'b0, q);
    sbit(1'b0, nb);
    for (int i = 3; i >= 0; i--) begin
      sbit(1'b0, q);
      part[i] = q;
    end
    check("t4_partial_bits", part, 4'h5);
    cs = 1'b1;
    clks(4);
    check("t4_abort_outputs", {dout, dout_oe, busy}, 3'b000);
    clks(4);
    check("t4_single_valid", valid_cnt, vc + 1);

    // New frame on channel 7, then overclocking in the tail
    ch_data[7*12 +: 12] = 12'h3C3;
    send_cmd(0, 1'b1, 3'd7);
    check("t4_channel", cmd_channel, 3'd7);
    sbit(1'b0, q);
    read_bits(res, nb);
    check("t4_null", nb, 1'b0);
    check("t4_data", res, 12'h3C3);
    ok = 1'b1;
    for (int i = 0; i < 8; i++) begin
      sbit(1'b0, q);
      if (!(q === 1'b0 && dout_oe === 1'b1 && busy === 1'b1)) ok = 1'b0;
    end
    check("t5_tail_zeros", ok, 1'b1);
    check("t5_valid_total", valid_cnt, vc + 2);
    cs = 1'b1;
    clks(5);
    check("t5_busy_cleared", {busy, dout_oe}, 2'b00);
    clks(4);

    // Reset mid-CMD, then a frame whose CS was low at release is ignored
    cs = 1'b0;
    clks(4);
    sbit(1'b1, q);
    sbit(1'b1, q);
    check("t6_busy_before_reset", busy, 1'b1);
    rst = 1'b1;
    #1;
    check("t6_reset_outputs",
          {26'd0, dout, dout_oe, cmd_valid, cmd_single, busy, cmd_channel}, 32'd0);
    clks(2);
    rst = 1'b0;
    vc = valid_cnt;
    sbit(1'b1, q);
    sbit(1'b1, q);
    sbit(1'b1, q);
    sbit(1'b1, q);
    sbit(1'b0, q);
    check("t6_ignored_frame_busy", busy, 1'b0);
    check("t6_ignored_frame_valid", valid_cnt, vc);
    cs = 1'b1;
    clks(8);

    ch_data[6*12 +: 12] = 12'h9A6;
    send_cmd(0, 1'b1, 3'd6);
    check("t6_valid_cnt", valid_cnt, vc + 1);
    check("t6_channel", cmd_channel, 3'd6);
    check("t6_single", cmd_single, 1'b1);
    sbit(1'b0, q);
    read_bits(res, nb);
    check("t6_data", res, 12'h9A6);
    end_frame();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
